// File: rtl/butterfly_pipe.sv
// butterfly_pipe: 3-stage pipelined radix-2 DIT butterfly.
// Computes A + W*B and A - W*B on packed {re, im} complex samples.
// Options per sample: conjugate twiddle (inverse FFT) and divide-by-2 scaling.
// Each output component saturates. A sideband tag travels with the sample.
// All stages advance together when the output register is empty or being
// drained, so a stall holds every stage, bubbles included.
module butterfly_pipe #(
   parameter int DW    = 18,
   parameter int TW    = 18,
   parameter int TFRAC = 17,
   parameter int TAGW  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2*DW-1:0]   a_in,
   input  logic [2*DW-1:0]   b_in,
   input  logic [2*TW-1:0]   w_in,
   input  logic              scale_in,
   input  logic              inv_in,
   input  logic [TAGW-1:0]   tag_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2*DW-1:0]   apwb_out,
   output logic [2*DW-1:0]   anwb_out,
   output logic              sat_out,
   output logic [TAGW-1:0]   tag_out
);

   localparam int PW = DW + TW;   // product width
   localparam int WW = PW + 1;    // W*B component width (difference/sum of products)
   localparam int SW = PW + 2;    // A +/- W*B width, cannot overflow

   localparam logic signed [TW-1:0] W_MAX = {1'b0, {(TW-1){1'b1}}};
   localparam logic signed [TW-1:0] W_MIN = {1'b1, {(TW-1){1'b0}}};
   localparam logic signed [WW-1:0] RND   = {{(WW-TFRAC){1'b0}}, 1'b1, {(TFRAC-1){1'b0}}};
   localparam logic signed [SW-1:0] ONE   = {{(SW-1){1'b0}}, 1'b1};
   localparam logic signed [SW-1:0] D_MAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [SW-1:0] D_MIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   // Clamp to the DW-bit output range; returns {saturated, value}.
   function automatic logic [DW:0] sat_fn(input logic signed [SW-1:0] v);
      if (v > D_MAX)      return {1'b1, D_MAX[DW-1:0]};
      else if (v < D_MIN) return {1'b1, D_MIN[DW-1:0]};
      else                return {1'b0, v[DW-1:0]};
   endfunction

   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Stage-1 inputs: optional conjugation of the twiddle imaginary part
   logic signed [TW-1:0] w_im_raw, w_im_eff;

   // Conjugate W when inverse mode is requested; -(-2^(TW-1)) clamps to max
   always_comb begin
      // NOTE: every always_comb target gets a default first so no latch is inferred.
      w_im_raw = w_in[TW-1:0];
      w_im_eff = w_im_raw;
      if (inv_in) w_im_eff = (w_im_raw == W_MIN) ? W_MAX : -w_im_raw;
   end

   logic                  s1_valid, s1_scale;
   logic signed [DW-1:0]  s1_a_re, s1_a_im, s1_b_re, s1_b_im;
   logic signed [TW-1:0]  s1_w_re, s1_w_im;
   logic [TAGW-1:0]       s1_tag;

   // Stage 1: capture the accepted sample and its per-sample controls
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: datapath registers are reset too, so reset leaves every stage fully defined.
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_scale <= 1'b0;
         s1_a_re  <= '0;
         s1_a_im  <= '0;
         s1_b_re  <= '0;
         s1_b_im  <= '0;
         s1_w_re  <= '0;
         s1_w_im  <= '0;
         s1_tag   <= '0;
      end else if (adv) begin
         // NOTE: non-blocking assignments keep all stages shifting in lock-step.
         s1_valid <= in_valid;
         s1_scale <= scale_in;
         s1_a_re  <= a_in[2*DW-1:DW];
         s1_a_im  <= a_in[DW-1:0];
         s1_b_re  <= b_in[2*DW-1:DW];
         s1_b_im  <= b_in[DW-1:0];
         s1_w_re  <= w_in[2*TW-1:TW];
         s1_w_im  <= w_im_eff;
         s1_tag   <= tag_in;
      end
   end

   // Sign-extended multiplier operands at full product width
   logic signed [PW-1:0] b_re_x, b_im_x, w_re_x, w_im_x;
   assign b_re_x = $signed({{TW{s1_b_re[DW-1]}}, s1_b_re});
   assign b_im_x = $signed({{TW{s1_b_im[DW-1]}}, s1_b_im});
   assign w_re_x = $signed({{DW{s1_w_re[TW-1]}}, s1_w_re});
   assign w_im_x = $signed({{DW{s1_w_im[TW-1]}}, s1_w_im});

   logic                  s2_valid, s2_scale;
   logic signed [DW-1:0]  s2_a_re, s2_a_im;
   logic signed [PW-1:0]  s2_p_rr, s2_p_ii, s2_p_ri, s2_p_ir;
   logic [TAGW-1:0]       s2_tag;

   // Stage 2: the four partial products, with A delayed alongside
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_scale <= 1'b0;
         s2_a_re  <= '0;
         s2_a_im  <= '0;
         s2_p_rr  <= '0;
         s2_p_ii  <= '0;
         s2_p_ri  <= '0;
         s2_p_ir  <= '0;
         s2_tag   <= '0;
      end else if (adv) begin
         s2_valid <= s1_valid;
         s2_scale <= s1_scale;
         s2_a_re  <= s1_a_re;
         s2_a_im  <= s1_a_im;
         s2_p_rr  <= b_re_x * w_re_x;
         s2_p_ii  <= b_im_x * w_im_x;
         s2_p_ri  <= b_re_x * w_im_x;
         s2_p_ir  <= b_im_x * w_re_x;
         s2_tag   <= s1_tag;
      end
   end

   logic signed [WW-1:0] wb_re, wb_im, wb_re_r, wb_im_r;
   logic signed [SW-1:0] a_re_x, a_im_x, wbr_x, wbi_x;
   logic signed [SW-1:0] p_re, p_im, n_re, n_im;
   logic [DW:0]          sp_re, sp_im, sn_re, sn_im;

   // Stage 3 datapath: complex product, round half up, add/sub, scale, clamp
   always_comb begin
      wb_re   = $signed({s2_p_rr[PW-1], s2_p_rr}) - $signed({s2_p_ii[PW-1], s2_p_ii});
      wb_im   = $signed({s2_p_ri[PW-1], s2_p_ri}) + $signed({s2_p_ir[PW-1], s2_p_ir});
      wb_re_r = (wb_re + RND) >>> TFRAC;
      wb_im_r = (wb_im + RND) >>> TFRAC;
      wbr_x   = $signed({wb_re_r[WW-1], wb_re_r});
      wbi_x   = $signed({wb_im_r[WW-1], wb_im_r});
      a_re_x  = $signed({{(SW-DW){s2_a_re[DW-1]}}, s2_a_re});
      a_im_x  = $signed({{(SW-DW){s2_a_im[DW-1]}}, s2_a_im});
      p_re    = a_re_x + wbr_x;
      p_im    = a_im_x + wbi_x;
      n_re    = a_re_x - wbr_x;
      n_im    = a_im_x - wbi_x;
      if (s2_scale) begin
         p_re = (p_re + ONE) >>> 1;
         p_im = (p_im + ONE) >>> 1;
         n_re = (n_re + ONE) >>> 1;
         n_im = (n_im + ONE) >>> 1;
      end
      sp_re = sat_fn(p_re);
      sp_im = sat_fn(p_im);
      sn_re = sat_fn(n_re);
      sn_im = sat_fn(n_im);
   end

   // Stage 3 register: results, saturation flag, tag and valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         apwb_out  <= '0;
         anwb_out  <= '0;
         sat_out   <= 1'b0;
         tag_out   <= '0;
      end else if (adv) begin
         out_valid <= s2_valid;
         apwb_out  <= {sp_re[DW-1:0], sp_im[DW-1:0]};
         anwb_out  <= {sn_re[DW-1:0], sn_im[DW-1:0]};
         sat_out   <= sp_re[DW] | sp_im[DW] | sn_re[DW] | sn_im[DW];
         tag_out   <= s2_tag;
      end
   end

endmodule

// File: tb/tb_butterfly_pipe.sv
// tb_butterfly_pipe: directed vectors plus randomized streaming against a
// plain-arithmetic reference model and an in-order scoreboard.
module tb_butterfly_pipe;

   localparam int DW    = 18;
   localparam int TW    = 18;
   localparam int TFRAC = 17;
   localparam int TAGW  = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid, in_ready, out_valid, out_ready;
   logic [2*DW-1:0]   a_in, b_in, apwb_out, anwb_out;
   logic [2*TW-1:0]   w_in;
   logic              scale_in, inv_in, sat_out;
   logic [TAGW-1:0]   tag_in, tag_out;

   butterfly_pipe #(.DW(DW), .TW(TW), .TFRAC(TFRAC), .TAGW(TAGW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a_in(a_in), .b_in(b_in), .w_in(w_in),
      .scale_in(scale_in), .inv_in(inv_in), .tag_in(tag_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .apwb_out(apwb_out), .anwb_out(anwb_out),
      .sat_out(sat_out), .tag_out(tag_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2*DW-1:0] apwb;
      logic [2*DW-1:0] anwb;
      logic            sat;
      logic [TAGW-1:0] tag;
      int              acc_cyc;
   } exp_t;

   exp_t            sb[$];
   int              total = 0, bad = 0, cyc = 0, n_out = 0, last_lat = 0;
   logic            got_out = 1'b0, held = 1'b0;
   logic [2*DW-1:0] last_apwb, last_anwb, held_apwb, held_anwb;
   logic            last_sat, held_sat;
   logic [TAGW-1:0] last_tag, held_tag;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic longint fdiv(input longint x, input longint d);
      longint q;
      q = x / d;
      if ((x % d != 0) && (x < 0)) q = q - 1;
      return q;
   endfunction

   function automatic longint clampd(input longint v, inout logic s);
      longint hi, lo;
      hi = (longint'(1) << (DW-1)) - 1;
      lo = -(longint'(1) << (DW-1));
      if (v > hi) begin s = 1'b1; return hi; end
      if (v < lo) begin s = 1'b1; return lo; end
      return v;
   endfunction

   function automatic logic [2*DW-1:0] pk(input longint re, input longint im);
      return {re[DW-1:0], im[DW-1:0]};
   endfunction

   function automatic logic [2*TW-1:0] pkw(input longint re, input longint im);
      return {re[TW-1:0], im[TW-1:0]};
   endfunction

   // Reference: exact complex arithmetic, floor-based round half up, clamp.
   function automatic exp_t model(input logic [2*DW-1:0] a, input logic [2*DW-1:0] b,
                                  input logic [2*TW-1:0] w, input logic sc, input logic iv,
                                  input logic [TAGW-1:0] tg);
      longint are, aim, bre, bim, wre, wim, one_w, wlim, wbr, wbi;
      longint r [4];
      logic   s;
      exp_t   e;
      are   = longint'($signed(a[2*DW-1:DW]));
      aim   = longint'($signed(a[DW-1:0]));
      bre   = longint'($signed(b[2*DW-1:DW]));
      bim   = longint'($signed(b[DW-1:0]));
      wre   = longint'($signed(w[2*TW-1:TW]));
      wim   = longint'($signed(w[TW-1:0]));
      one_w = longint'(1) << TFRAC;
      wlim  = longint'(1) << (TW-1);
      if (iv) begin
         wim = -wim;
         if (wim > wlim - 1) wim = wlim - 1;
      end
      wbr  = fdiv(bre*wre - bim*wim + one_w/2, one_w);
      wbi  = fdiv(bre*wim + bim*wre + one_w/2, one_w);
      r[0] = are + wbr;
      r[1] = aim + wbi;
      r[2] = are - wbr;
      r[3] = aim - wbi;
      s = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (sc) r[k] = fdiv(r[k] + 1, 2);
         r[k] = clampd(r[k], s);
      end
      e.apwb    = pk(r[0], r[1]);
      e.anwb    = pk(r[2], r[3]);
      e.sat     = s;
      e.tag     = tg;
      e.acc_cyc = 0;
      return e;
   endfunction

   function automatic longint rcomp(input int w);
      case ($urandom_range(0, 7))
         0:       return (longint'(1) << (w-1)) - 1;
         1:       return -(longint'(1) << (w-1));
         default: return longint'($urandom_range(0, (1 << w) - 1)) - (longint'(1) << (w-1));
      endcase
   endfunction

   // One clock: sample handshakes mid-cycle, score outputs, then cross the edge.
   task automatic step();
      exp_t e;
      #2;
      if (out_valid && out_ready) begin
         got_out = 1'b1;
         n_out++;
         if (sb.size() == 0) check("spurious_out", 1, 0);
         else begin
            e = sb.pop_front();
            check("apwb", apwb_out, e.apwb);
            check("anwb", anwb_out, e.anwb);
            check("sat", sat_out, e.sat);
            check("tag", tag_out, e.tag);
            last_apwb = apwb_out;
            last_anwb = anwb_out;
            last_sat  = sat_out;
            last_tag  = tag_out;
            last_lat  = cyc - e.acc_cyc;
         end
      end
      if (held) begin
         check("hold_valid", out_valid, 1);
         check("hold_apwb", apwb_out, held_apwb);
         check("hold_anwb", anwb_out, held_anwb);
         check("hold_tag", tag_out, held_tag);
         check("hold_sat", sat_out, held_sat);
      end
      held      = out_valid && !out_ready;
      held_apwb = apwb_out;
      held_anwb = anwb_out;
      held_tag  = tag_out;
      held_sat  = sat_out;
      if (in_valid && in_ready) begin
         e = model(a_in, b_in, w_in, scale_in, inv_in, tag_in);
         e.acc_cyc = cyc;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic one_shot(input longint are, input longint aim, input longint bre,
                           input longint bim, input longint wre, input longint wim,
                           input logic sc, input logic iv, input logic [TAGW-1:0] tg);
      a_in      = pk(are, aim);
      b_in      = pk(bre, bim);
      w_in      = pkw(wre, wim);
      scale_in  = sc;
      inv_in    = iv;
      tag_in    = tg;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      got_out   = 1'b0;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 20 && !got_out; i++) step();
      check("one_shot_done", got_out, 1);
      check("latency", last_lat, 3);
   endtask

   initial begin
      int sent, n0;
      logic pre;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a_in = '0; b_in = '0; w_in = '0; scale_in = 1'b0; inv_in = 1'b0; tag_in = '0;
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_apwb", apwb_out, 0);
      check("rst_anwb", anwb_out, 0);
      check("rst_sat", sat_out, 0);
      check("rst_tag", tag_out, 0);
      check("rst_in_ready", in_ready, 1);
      #20 rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic, inverse and scaled with A=55+33j, B=1+77j, W=-j
      one_shot(55, 33, 1, 77, 0, -131072, 1'b0, 1'b0, 8'h11);
      check("basic_apwb", last_apwb, pk(132, 32));
      check("basic_anwb", last_anwb, pk(-22, 34));
      check("basic_sat", last_sat, 0);
      check("basic_tag", last_tag, 8'h11);
      one_shot(55, 33, 1, 77, 0, -131072, 1'b0, 1'b1, 8'h12);
      check("inv_apwb", last_apwb, pk(-22, 34));
      check("inv_anwb", last_anwb, pk(132, 32));
      one_shot(55, 33, 1, 77, 0, -131072, 1'b1, 1'b0, 8'h13);
      check("scale_apwb", last_apwb, pk(66, 16));
      check("scale_anwb", last_anwb, pk(-11, 17));

      // Saturation, then a clean sample clears the flag
      one_shot(131071, 0, 131071, 0, -131072, 0, 1'b0, 1'b0, 8'h14);
      check("sat_apwb", last_apwb, pk(0, 0));
      check("sat_anwb", last_anwb, pk(131071, 0));
      check("sat_flag", last_sat, 1);
      one_shot(55, 33, 1, 77, 0, -131072, 1'b0, 1'b0, 8'h15);
      check("sat_clear", last_sat, 0);

      // Rounding at exactly +/-0.5
      one_shot(0, 0, 1, 0, 65536, 0, 1'b0, 1'b0, 8'h16);
      check("rnd_pos_apwb", last_apwb, pk(1, 0));
      check("rnd_pos_anwb", last_anwb, pk(-1, 0));
      one_shot(0, 0, -1, 0, 65536, 0, 1'b0, 1'b0, 8'h17);
      check("rnd_neg_apwb", last_apwb, pk(0, 0));
      check("rnd_neg_anwb", last_anwb, pk(0, 0));

      // Streaming with backpressure in cycles 5..7
      sent = 0;
      n0   = n_out;
      for (int c = 0; c < 40 && (sent < 8 || sb.size() > 0); c++) begin
         out_ready = !(c >= 5 && c <= 7);
         in_valid  = (sent < 8);
         a_in      = pk(sent * 1000 + 3, -sent * 77);
         b_in      = pk(-sent * 501, sent * 919 + 1);
         w_in      = pkw(92682 - sent * 3000, -92682 + sent * 5000);
         scale_in  = sent[0];
         inv_in    = sent[1];
         tag_in    = sent[TAGW-1:0];
         #1;
         if (c >= 5 && c <= 7) check("bp_in_ready_low", in_ready, 0);
         pre = in_valid && in_ready;
         step();
         if (pre) sent++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp_count", n_out - n0, 8);

      // Randomized streaming with random stalls
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         a_in      = pk(rcomp(DW), rcomp(DW));
         b_in      = pk(rcomp(DW), rcomp(DW));
         w_in      = pkw(rcomp(TW), rcomp(TW));
         scale_in  = $urandom_range(0, 1);
         inv_in    = $urandom_range(0, 1);
         tag_in    = $urandom_range(0, 255);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 50 && sb.size() > 0; i++) step();
      check("rand_drained", sb.size(), 0);

      // Reset with two samples in flight
      a_in = pk(55, 33); b_in = pk(1, 77); w_in = pkw(0, -131072);
      scale_in = 1'b0; inv_in = 1'b0;
      in_valid = 1'b1; tag_in = 8'hA1; step();
      tag_in = 8'hA2; step();
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_apwb", apwb_out, 0);
      check("mid_rst_anwb", anwb_out, 0);
      check("mid_rst_sat", sat_out, 0);
      check("mid_rst_tag", tag_out, 0);
      sb.delete();
      held = 1'b0;
      step();
      rst_n = 1'b1;
      n0 = n_out;
      for (int i = 0; i < 10; i++) step();
      check("no_stale_out", n_out - n0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/butterfly_pipe.md
Name: butterfly_pipe

Overview:
Parametrised, 3-stage pipelined radix-2 DIT butterfly that computes A+W·B and A−W·B on packed complex samples, with a valid/ready handshake.
Successor to the combinational butterfly unit. Adds configurable data and twiddle widths, convergent-free rounding, per-sample divide-by-2 scaling, inverse (conjugate-twiddle) mode, saturation with a flag, and a sideband tag.
Sits between the FFT stage address generator / twiddle ROM and the stage write-back buffer.

Parameters:
DW, 18, width of each real/imag component of A, B and outputs (signed two's complement)
TW, 18, width of each real/imag component of twiddle W (signed)
TFRAC, 17, fractional bits of W (W = value / 2^TFRAC; −1.0 = −2^TFRAC representable, +1.0 not)
TAGW, 8, width of pass-through sideband tag

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  block accepts input this cycle
a_in  in  2*DW  A, {re[2DW-1:DW], im[DW-1:0]}
b_in  in  2*DW  B, same packing
w_in  in  2*TW  twiddle, {re, im}
scale_in  in  1  1 = outputs divided by 2 (per-sample, travels with data)
inv_in  in  1  1 = use conj(W) (inverse FFT), per-sample
tag_in  in  TAGW  sideband, returned unchanged with result
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
apwb_out  out  2*DW  A + W·B, {re, im}
anwb_out  out  2*DW  A − W·B, {re, im}
sat_out  out  1  any of the 4 output components saturated for this sample
tag_out  out  TAGW  tag of current result

Behaviour:
- Reset (async, rst_n=0): all stage valids 0; out_valid=0, apwb_out=0, anwb_out=0, sat_out=0, tag_out=0; in_ready follows the advance rule (1 after reset). Reset mid-pipeline discards in-flight samples; no partial output.
- Pipeline advance: adv = !out_valid || out_ready. in_ready = adv. Transfer occurs when in_valid && in_ready.
- When adv=1, all three stages shift together; stage-1 valid takes (in_valid && in_ready).
- When adv=0, every stage holds, including bubbles; outputs stay stable while out_valid && !out_ready.
- Latency: exactly 3 clk edges from accepted input to out_valid when unstalled. Throughput: 1 sample/cycle.
- Stage 1: register A, B, W, scale, inv, tag. If inv, W_im := −W_im. Negating −2^(TW−1) saturates to 2^(TW−1)−1.
- Stage 2: four signed products B_re·W_re, B_im·W_im, B_re·W_im, B_im·W_re at DW+TW bits. A delayed alongside.
- Stage 3:
  - WB_re = P_rr − P_ii, WB_im = P_ri + P_ir at DW+TW+1 bits.
  - Round: add 2^(TFRAC−1), then arithmetic shift right by TFRAC (round half up).
  - Sums: A ± WB, sign-extended, no intermediate overflow.
  - If scale: add 1, arithmetic shift right 1.
  - Saturate each component to [−2^(DW−1), 2^(DW−1)−1]. sat = OR of the four component saturations.
  - Register results, sat, tag and valid.
- scale/inv/tag are per-sample; changing them between consecutive samples affects only the respective sample.
- No state beyond pipeline registers; no FSM other than the per-stage valid bits.

Test Plan:
- Basic: A=55+33j, B=1+77j, W=(0, −131072) i.e. −j, scale=0, inv=0 -> apwb=132+32j, anwb=−22+34j, sat=0, out_valid exactly 3 cycles after accept.
- Inverse: same A,B,W with inv=1 -> apwb=−22+34j, anwb=132+32j. Scale: inv=0, scale=1 -> apwb=66+16j, anwb=−11+17j.
- Saturation: A=131071+0j, B=131071+0j, W=(−131072,0) -> apwb=0+0j, anwb=131071+0j (clamped from 262142), sat_out=1. Next sample with the basic vectors -> sat_out=0.
- Streaming/backpressure: 8 back-to-back samples with tags 0..7, out_ready low for cycles 5–7 -> in_ready low same cycles, outputs held stable, all 8 results in order with matching tags, none lost or duplicated.
- Rounding: A=0, B=1+0j, W=(65536,0) (0.5) -> apwb=1+0j (0.5 rounds up), anwb=−1+0j (−0.5 rounds up to 0 before subtract, giving 0−1... check: WB=1 after round, so anwb=−1). With B=−1 -> WB rounds to 0, apwb=anwb=0.
- Reset: assert rst_n=0 with 2 samples in flight -> out_valid=0 and all outputs 0 immediately; after release, no stale result ever appears.
